// File: rtl/spine_port_arbiter.sv
// spine_port_arbiter
// ------------------
// Round-robin arbiter for one output port of the group-7 spine router. It
// picks one of NUM_PORTS input ports and grants it a burst of up to HOLD_MAX
// flits. While the burst runs it pops the owner's input FIFO and registers
// each flit onto the output port. A full output FIFO stalls the burst
// without losing or repeating any flit.
//
// Ports:
//   clk           : single clock, rising edge
//   reset         : synchronous, active-high reset
//   req           : [NUM_PORTS]        per-input head-flit-present flags
//   in_data       : [NUM_PORTS*DWIDTH] flattened head flits, port i at i*DWIDTH
//   out_fifo_full : output FIFO cannot take a flit this cycle
//   pop           : [NUM_PORTS] combinational one-hot head-flit consume strobe
//   grant         : [NUM_PORTS] registered one-hot owner, zero when idle
//   out_data      : [DWIDTH] registered flit to the output FIFO
//   out_valid     : registered write strobe for out_data
//   busy          : registered, high while a grant is held
module spine_port_arbiter #(
    parameter int NUM_PORTS = 11,
    parameter int DWIDTH    = 16,
    parameter int HOLD_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
    input  logic                          out_fifo_full,
    output logic [NUM_PORTS-1:0]          pop,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [DWIDTH-1:0]             out_data,
    output logic                          out_valid,
    output logic                          busy
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   rr_ptr_r;
    logic [CW-1:0]   hold_cnt_r;

    logic            pick_found_s;
    logic [IW-1:0]   pick_idx_s;
    logic            owner_req_s;
    logic            xfer_s;
    logic            last_xfer_s;
    logic [IW-1:0]   next_rr_s;
    logic [DWIDTH-1:0] owner_data_s;

    // One-hot vector with only bit idx set.
    function automatic logic [NUM_PORTS-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_PORTS-1:0] base;
        base = {{(NUM_PORTS-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

    // Round-robin search: first requesting port at or above rr_ptr, wrapping.
    always_comb begin
        int cand;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(rr_ptr_r) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end else begin
                cand = cand;
            end
            if (!pick_found_s && req[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'(cand);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Transfer qualification for the current owner and derived strobes.
    always_comb begin
        owner_req_s  = req[owner_r];
        owner_data_s = in_data[owner_r*DWIDTH +: DWIDTH];
        // A transfer needs the owner's head flit and room downstream; reset
        // suppresses it so no flit is consumed while state is being cleared.
        xfer_s       = (state_r == ST_BUSY) && owner_req_s && !out_fifo_full && !reset;
        last_xfer_s  = xfer_s && (hold_cnt_r == CW'(HOLD_MAX - 1));
        if (xfer_s) begin
            pop = onehot(owner_r);
        end else begin
            pop = '0;
        end
        if (owner_r == IW'(NUM_PORTS - 1)) begin
            next_rr_s = '0;
        end else begin
            next_rr_s = owner_r + IW'(1);
        end
    end

    // Arbitration FSM with registered grant, busy and output flit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            hold_cnt_r <= '0;
            grant      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    // Granting only when the output has room avoids taking
                    // ownership just to stall in the first busy cycle.
                    if (pick_found_s && !out_fifo_full) begin
                        owner_r    <= pick_idx_s;
                        grant      <= onehot(pick_idx_s);
                        hold_cnt_r <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req_s) begin
                        // Owner ran dry: give the port up without a transfer.
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        rr_ptr_r  <= next_rr_s;
                    end else if (out_fifo_full) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_data   <= owner_data_s;
                        out_valid  <= 1'b1;
                        hold_cnt_r <= hold_cnt_r + CW'(1);
                        // The burst-limit transfer completes and releases together.
                        if (last_xfer_s) begin
                            state_r  <= ST_IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            rr_ptr_r <= next_rr_s;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant     <= '0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spine_port_arbiter.sv
// Directed bench for spine_port_arbiter. Each input FIFO is modelled as a
// counter: port i presents flit {i, cnt[i]} and advances after each expected
// pop, so in_data[3] walks 0x0300, 0x0301, ...
module tb_spine_port_arbiter;

    localparam int NP = 11;
    localparam int DW = 16;
    localparam int HM = 4;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    req;
    logic [NP*DW-1:0] in_data;
    logic             out_fifo_full;
    logic [NP-1:0]    pop;
    logic [NP-1:0]    grant;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             busy;

    logic [7:0] cnt [NP];
    int tests;
    int fails;

    typedef struct {
        logic          rst;
        logic [NP-1:0] rq;
        logic          full;
        logic [NP-1:0] e_pop;
        logic [NP-1:0] e_grant;
        logic          e_busy;
        logic          e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs [16];

    spine_port_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW), .HOLD_MAX(HM)) dut (
        .clk(clk), .reset(reset), .req(req), .in_data(in_data),
        .out_fifo_full(out_fifo_full), .pop(pop), .grant(grant),
        .out_data(out_data), .out_valid(out_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input FIFO head flits from the per-port counters.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            in_data[i*DW +: DW] = {8'(i), cnt[i]};
        end
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, advance FIFOs past posedge.
    task automatic cyc(input string nm, input logic rst, input logic [NP-1:0] rq, input logic full,
                       input logic [NP-1:0] e_pop, input logic [NP-1:0] e_grant,
                       input logic e_busy, input logic e_valid, input logic chk_d,
                       input logic [DW-1:0] e_data);
        @(negedge clk);
        reset = rst;
        req = rq;
        out_fifo_full = full;
        #1;
        cmp(nm, "pop", 32'(pop), 32'(e_pop));
        cmp(nm, "grant", 32'(grant), 32'(e_grant));
        cmp(nm, "busy", 32'(busy), 32'(e_busy));
        cmp(nm, "out_valid", 32'(out_valid), 32'(e_valid));
        if (chk_d || e_valid) begin
            cmp(nm, "out_data", 32'(out_data), 32'(e_data));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (e_pop[i]) begin
                cnt[i] = cnt[i] + 8'd1;
            end
        end
    endtask

    initial begin
        int own  [5];
        int base [5];
        logic [NP-1:0] oh;
        logic [DW-1:0] prev;

        tests = 0;
        fails = 0;
        for (int i = 0; i < NP; i++) cnt[i] = 8'd0;
        reset = 1'b1;
        req = 11'h7FF;
        out_fifo_full = 1'b0;
        @(posedge clk);
        #1;

        //           rst   req      full  pop      grant    busy  valid data
        vecs[0]  = '{1'b1, 11'h7FF, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 11'h7FF, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 11'h7FF, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 11'h7FF, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 11'h7FF, 1'b0, 11'h001, 11'h001, 1'b1, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 11'h000, 1'b0, 11'h000, 11'h001, 1'b1, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 11'h008, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 11'h008, 1'b0, 11'h008, 11'h008, 1'b1, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 11'h008, 1'b0, 11'h008, 11'h008, 1'b1, 1'b1, 16'h0300};
        vecs[10] = '{1'b0, 11'h008, 1'b0, 11'h008, 11'h008, 1'b1, 1'b1, 16'h0301};
        vecs[11] = '{1'b0, 11'h008, 1'b0, 11'h008, 11'h008, 1'b1, 1'b1, 16'h0302};
        vecs[12] = '{1'b0, 11'h008, 1'b0, 11'h000, 11'h000, 1'b0, 1'b1, 16'h0303};
        vecs[13] = '{1'b0, 11'h008, 1'b0, 11'h008, 11'h008, 1'b1, 1'b0, 16'h0303};
        vecs[14] = '{1'b0, 11'h000, 1'b0, 11'h000, 11'h008, 1'b1, 1'b1, 16'h0304};
        vecs[15] = '{1'b0, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 16'h0304};

        // Reset with all requesting, first grant to port 0, then port 3 alone.
        for (int v = 0; v < 16; v++) begin
            cyc($sformatf("vec%0d", v), vecs[v].rst, vecs[v].rq, vecs[v].full,
                vecs[v].e_pop, vecs[v].e_grant, vecs[v].e_busy, vecs[v].e_valid,
                1'b1, vecs[v].e_data);
        end

        // Round robin over ports 0, 5, 10 from a fresh reset.
        cyc("rr_rst", 1'b1, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
        own  = '{0, 5, 10, 0, 5};
        base = '{1, 0, 0, 5, 4};
        prev = 16'h0000;
        for (int b = 0; b < 5; b++) begin
            oh = 11'h001 << own[b];
            cyc($sformatf("rr%0d_idle", b), 1'b0, 11'h421, 1'b0, 11'h000, 11'h000,
                1'b0, (b > 0), 1'b0, prev);
            for (int j = 0; j < HM; j++) begin
                cyc($sformatf("rr%0d_x%0d", b, j), 1'b0, 11'h421, 1'b0, oh, oh,
                    1'b1, (j > 0), 1'b0, prev);
                prev = {8'(own[b]), 8'(base[b] + j)};
            end
        end

        // Short burst: port 7 drops after two pops, port 8 is next (rr_ptr=8).
        cyc("sb0", 1'b0, 11'h180, 1'b0, 11'h000, 11'h000, 1'b0, 1'b1, 1'b0, 16'h0507);
        cyc("sb1", 1'b0, 11'h180, 1'b0, 11'h080, 11'h080, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("sb2", 1'b0, 11'h180, 1'b0, 11'h080, 11'h080, 1'b1, 1'b1, 1'b0, 16'h0700);
        cyc("sb3", 1'b0, 11'h100, 1'b0, 11'h000, 11'h080, 1'b1, 1'b1, 1'b0, 16'h0701);
        cyc("sb4", 1'b0, 11'h180, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b1, 16'h0701);
        cyc("sb5", 1'b0, 11'h180, 1'b0, 11'h100, 11'h100, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("sb6", 1'b0, 11'h080, 1'b0, 11'h000, 11'h100, 1'b1, 1'b1, 1'b0, 16'h0800);
        cyc("sb7", 1'b0, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Backpressure on port 2's burst (rr_ptr=9 wraps to 2).
        cyc("bp0", 1'b0, 11'h004, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc("bp1", 1'b0, 11'h004, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc("bp2", 1'b0, 11'h004, 1'b0, 11'h004, 11'h004, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("bp3", 1'b0, 11'h004, 1'b1, 11'h000, 11'h004, 1'b1, 1'b1, 1'b0, 16'h0200);
        cyc("bp4", 1'b0, 11'h004, 1'b1, 11'h000, 11'h004, 1'b1, 1'b0, 1'b1, 16'h0200);
        cyc("bp5", 1'b0, 11'h004, 1'b1, 11'h000, 11'h004, 1'b1, 1'b0, 1'b1, 16'h0200);
        cyc("bp6", 1'b0, 11'h004, 1'b0, 11'h004, 11'h004, 1'b1, 1'b0, 1'b1, 16'h0200);
        cyc("bp7", 1'b0, 11'h004, 1'b0, 11'h004, 11'h004, 1'b1, 1'b1, 1'b0, 16'h0201);
        cyc("bp8", 1'b0, 11'h004, 1'b0, 11'h004, 11'h004, 1'b1, 1'b1, 1'b0, 16'h0202);
        cyc("bp9", 1'b0, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b1, 1'b0, 16'h0203);
        cyc("bp10", 1'b0, 11'h000, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b1, 16'h0203);

        // Reset while port 4 owns after its second pop.
        cyc("mr0", 1'b0, 11'h210, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc("mr1", 1'b0, 11'h210, 1'b0, 11'h010, 11'h010, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("mr2", 1'b0, 11'h210, 1'b0, 11'h010, 11'h010, 1'b1, 1'b1, 1'b0, 16'h0400);
        cyc("mr3", 1'b1, 11'h210, 1'b0, 11'h000, 11'h010, 1'b1, 1'b1, 1'b0, 16'h0401);
        cyc("mr4", 1'b0, 11'h210, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0, 1'b1, 16'h0000);
        cyc("mr5", 1'b0, 11'h210, 1'b0, 11'h010, 11'h010, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("mr6", 1'b0, 11'h000, 1'b0, 11'h000, 11'h010, 1'b1, 1'b1, 1'b0, 16'h0402);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
